// File: rtl/sa_ram_pkg.sv
// Shared helpers for the sa_ram family of RAM models.
//   clog2_safe    : address width for a given depth, never below 1 bit
//   num_lanes     : number of write-mask lanes for a data width / lane width
//   addr_oob      : true when an address falls outside the populated depth
//   rw_contention : true when a masked write and a read hit the same address
package sa_ram_pkg;

  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

  function automatic int num_lanes(input int dw, input int mask_w);
    return dw / mask_w;
  endfunction

  function automatic logic addr_oob(input logic [31:0] addr, input int unsigned depth);
    return addr >= depth;
  endfunction

  function automatic logic rw_contention(input logic we, input logic re,
                                         input logic same_addr, input logic any_lane);
    return we && re && same_addr && any_lane;
  endfunction

endpackage

// File: rtl/sa_ram_outreg.sv
// Output register for the sa_ram family: captures either array data or
// bypass data when ore is high, and tracks whether dout holds meaningful data.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   ore       : output-register enable; dout/dout_vld hold while low
//   byp_sel   : choose dbyp over dram (only sampled with ore)
//   dbyp      : bypass data
//   dram      : combinational array read data
//   s1_vld    : a read was issued in the previous cycle
//   dout      : registered read data
//   dout_vld  : dout holds data from a completed read or a bypass
module sa_ram_outreg #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ore,
  input  logic          byp_sel,
  input  logic [DW-1:0] dbyp,
  input  logic [DW-1:0] dram,
  input  logic          s1_vld,
  output logic [DW-1:0] dout,
  output logic          dout_vld
);

  // Stage 2: output register with bypass mux
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else if (ore) begin
      dout     <= byp_sel ? dbyp : dram;
      dout_vld <= s1_vld | byp_sel;
    end
  end

endmodule

// File: rtl/sa_ram_rwsthp_param.sv
// Parametrised 1W1R RAM model with registered read address, registered
// output with bypass, per-lane write mask, output-valid flag and a sticky
// out-of-range access flag. Read latency is two cycles: re captures the
// address, ore loads the output register.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (control only;
//                     the storage array is never reset)
//   ra, re          : read address / read enable (captures ra)
//   ore             : output-register enable
//   dout, dout_vld  : registered read data and its valid flag
//   wa, we          : write address / write enable
//   wmask, di       : per-lane write enable and write data
//   byp_sel, dbyp   : load dbyp into the output register instead of array data
//   err_clr         : clears err_oob (a same-cycle new violation wins)
//   err_oob         : sticky out-of-range read/write flag
//   pwrbus_ram_pd   : power bus, functionally ignored
module sa_ram_rwsthp_param
  import sa_ram_pkg::*;
#(
  parameter int DW                                     = 4,
  parameter int DEPTH                                  = 20,
  parameter int AW                                     = clog2_safe(DEPTH),
  parameter int MASK_W                                 = DW,
  parameter bit FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1'b0,
  localparam int NM                                    = num_lanes(DW, MASK_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra,
  input  logic          re,
  input  logic          ore,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic [AW-1:0] wa,
  input  logic          we,
  input  logic [NM-1:0] wmask,
  input  logic [DW-1:0] di,
  input  logic          byp_sel,
  input  logic [DW-1:0] dbyp,
  input  logic          err_clr,
  output logic          err_oob,
  input  logic [31:0]   pwrbus_ram_pd
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ra_d;
  logic          s1_vld;
  logic [DW-1:0] dout_ram;
  logic          wa_oob;
  logic          ra_oob;
  logic          ra_d_oob;
  logic          unused_pwrbus;

  assign unused_pwrbus = ^pwrbus_ram_pd;

  assign wa_oob   = addr_oob(32'(wa), DEPTH);
  assign ra_oob   = addr_oob(32'(ra), DEPTH);
  assign ra_d_oob = addr_oob(32'(ra_d), DEPTH);

  // Write port: masked lane update, out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (we && !wa_oob) begin
      for (int i = 0; i < NM; i++) begin
        if (wmask[i]) mem[wa][i*MASK_W +: MASK_W] <= di[i*MASK_W +: MASK_W];
      end
    end
  end

  // Stage 1: read address register; s1_vld tracks re every cycle so a
  // reset in the middle of a read discards it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_d   <= '0;
      s1_vld <= 1'b0;
    end else begin
      if (re) ra_d <= ra;
      s1_vld <= re;
    end
  end

  // The array is read after the address edge, so a write at the same edge
  // as re is seen, while a write at the ore edge is not.
  assign dout_ram = ra_d_oob ? '0 : mem[ra_d];

  // Sticky error flag: a new violation outranks a clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_oob <= 1'b0;
    end else if ((we && wa_oob) || (re && ra_oob)) begin
      err_oob <= 1'b1;
    end else if (err_clr) begin
      err_oob <= 1'b0;
    end
  end

  sa_ram_outreg #(
    .DW(DW)
  ) u_outreg (
    .clk      (clk),
    .rst      (rst),
    .ore      (ore),
    .byp_sel  (byp_sel),
    .dbyp     (dbyp),
    .dram     (dout_ram),
    .s1_vld   (s1_vld),
    .dout     (dout),
    .dout_vld (dout_vld)
  );

  // Simulation-only contention report; reported as a warning so a model
  // user can still observe the defined collision behaviour.
  always @(posedge clk) begin
    if (FORCE_CONTENTION_ASSERTION_RESET_ACTIVE || !rst) begin
      assert (!rw_contention(we, re, wa == ra, |wmask))
        else $warning("sa_ram_rwsthp_param: read/write contention at address %0d", wa);
    end
  end

endmodule

// File: tb/tb_sa_ram_rwsthp_param.sv
module tb_sa_ram_rwsthp_param;

  localparam int DW     = 4;
  localparam int DEPTH  = 20;
  localparam int AW     = 5;
  localparam int MASK_W = 1;
  localparam int NM     = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ra;
  logic          re;
  logic          ore;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic [AW-1:0] wa;
  logic          we;
  logic [NM-1:0] wmask;
  logic [DW-1:0] di;
  logic          byp_sel;
  logic [DW-1:0] dbyp;
  logic          err_clr;
  logic          err_oob;
  logic [31:0]   pwrbus_ram_pd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sa_ram_rwsthp_param #(
    .DW     (DW),
    .DEPTH  (DEPTH),
    .MASK_W (MASK_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ra            (ra),
    .re            (re),
    .ore           (ore),
    .dout          (dout),
    .dout_vld      (dout_vld),
    .wa            (wa),
    .we            (we),
    .wmask         (wmask),
    .di            (di),
    .byp_sel       (byp_sel),
    .dbyp          (dbyp),
    .err_clr       (err_clr),
    .err_oob       (err_oob),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  initial begin
    rst = 1'b1; ra = '0; re = 1'b0; ore = 1'b0; wa = '0; we = 1'b0;
    wmask = '0; di = '0; byp_sel = 1'b0; dbyp = '0; err_clr = 1'b0;
    pwrbus_ram_pd = 32'h0;
    step(); step();
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_vld", 32'(dout_vld), 32'h0);
    check("rst_err", 32'(err_oob), 32'h0);
    rst = 1'b0;
    step();

    // Basic write then two-cycle read
    we = 1'b1; wa = 5'd7; di = 4'hA; wmask = 4'hF;
    step();
    we = 1'b0; re = 1'b1; ra = 5'd7;
    step();
    re = 1'b0; ore = 1'b1;
    step();
    ore = 1'b0;
    check("basic_dout", 32'(dout), 32'hA);
    check("basic_vld", 32'(dout_vld), 32'h1);

    // Reset in the middle of a read
    re = 1'b1; ra = 5'd7;
    step();
    re = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_dout", 32'(dout), 32'h0);
    check("midrst_vld", 32'(dout_vld), 32'h0);
    check("midrst_err", 32'(err_oob), 32'h0);
    step();
    rst = 1'b0;
    ore = 1'b1;
    step();
    ore = 1'b0;
    check("midrst_ore_only_vld", 32'(dout_vld), 32'h0);

    // Partial mask write
    we = 1'b1; wa = 5'd3; di = 4'h0; wmask = 4'hF;
    step();
    di = 4'hF; wmask = 4'b0101;
    step();
    we = 1'b0; re = 1'b1; ra = 5'd3;
    step();
    re = 1'b0; ore = 1'b1;
    step();
    ore = 1'b0;
    check("mask_partial", 32'(dout), 32'h5);
    we = 1'b1; wa = 5'd3; di = 4'hA; wmask = 4'b0000;
    step();
    we = 1'b0; re = 1'b1; ra = 5'd3;
    step();
    re = 1'b0; ore = 1'b1;
    step();
    ore = 1'b0;
    check("mask_zero", 32'(dout), 32'h5);

    // Write at the same edge as re: new data
    we = 1'b1; wa = 5'd5; di = 4'h6; wmask = 4'hF; re = 1'b1; ra = 5'd5;
    step();
    we = 1'b0; re = 1'b0; ore = 1'b1;
    step();
    ore = 1'b0;
    check("coll_re_new", 32'(dout), 32'h6);

    // Write at the ore edge: old data, next read sees the new value
    re = 1'b1; ra = 5'd5;
    step();
    re = 1'b0; ore = 1'b1; we = 1'b1; wa = 5'd5; di = 4'h9; wmask = 4'hF;
    step();
    we = 1'b0; ore = 1'b0;
    check("coll_ore_old", 32'(dout), 32'h6);
    re = 1'b1; ra = 5'd5;
    step();
    re = 1'b0; ore = 1'b1;
    step();
    ore = 1'b0;
    check("coll_next_new", 32'(dout), 32'h9);
    check("coll_next_vld", 32'(dout_vld), 32'h1);

    // ore without a preceding read and without bypass: not valid
    ore = 1'b1;
    step();
    ore = 1'b0;
    check("noread_vld", 32'(dout_vld), 32'h0);
    check("noread_dout", 32'(dout), 32'h9);

    // Bypass and hold
    ore = 1'b1; byp_sel = 1'b1; dbyp = 4'hC;
    step();
    ore = 1'b0; byp_sel = 1'b0; dbyp = 4'h0;
    check("byp_dout", 32'(dout), 32'hC);
    check("byp_vld", 32'(dout_vld), 32'h1);
    step();
    check("hold1", 32'(dout), 32'hC);
    byp_sel = 1'b1; dbyp = 4'h3;
    step();
    byp_sel = 1'b0; dbyp = 4'h0;
    check("hold2_byp_ignored", 32'(dout), 32'hC);
    step();
    check("hold3", 32'(dout), 32'hC);

    // Out-of-range accesses
    check("oob_pre", 32'(err_oob), 32'h0);
    we = 1'b1; wa = 5'd20; di = 4'hF; wmask = 4'hF;
    step();
    we = 1'b0;
    check("oob_wr_err", 32'(err_oob), 32'h1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("oob_clr", 32'(err_oob), 32'h0);
    re = 1'b1; ra = 5'd25;
    step();
    re = 1'b0; ore = 1'b1;
    check("oob_rd_err", 32'(err_oob), 32'h1);
    step();
    ore = 1'b0;
    check("oob_rd_dout", 32'(dout), 32'h0);
    check("oob_rd_vld", 32'(dout_vld), 32'h1);
    err_clr = 1'b1; re = 1'b1; ra = 5'd25;
    step();
    re = 1'b0;
    check("oob_set_wins", 32'(err_oob), 32'h1);
    step();
    err_clr = 1'b0;
    check("oob_clr_alone", 32'(err_oob), 32'h0);

    // Array untouched by the out-of-range write
    re = 1'b1; ra = 5'd7;
    step();
    re = 1'b0; ore = 1'b1;
    step();
    ore = 1'b0;
    check("oob_array_intact", 32'(dout), 32'hA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sa_ram_rwsthp_param.md
Name: sa_ram_rwsthp_param

Overview:
Parametrised two-port RAM model: one write port and one read port, for the FPGA RAM model library. It replaces the fixed-size 1R1W models with an address-registered read, a registered output with bypass, per-lane write mask, an output-valid flag, and out-of-range address detection.
Control state is reset; the storage array is never reset. It is used wherever a systolic-array buffer needs DEPTH x DW storage.

Parameters:
- DW, 4, data width in bits.
- DEPTH, 20, number of words; must be ≥2.
- AW, $clog2(DEPTH), address width; derived, not overridden.
- MASK_W, DW, write-mask lane width. DW % MASK_W == 0; NM = DW/MASK_W.
- FORCE_CONTENTION_ASSERTION_RESET_ACTIVE, 1'b0, if 1 the simulation contention assertion also fires during rst.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ra  in  AW  read address.
- re  in  1  read enable; captures ra.
- ore  in  1  output-register enable.
- dout  out  DW  registered read data.
- dout_vld  out  1  dout holds data from a completed read or bypass.
- wa  in  AW  write address.
- we  in  1  write enable.
- wmask  in  NM  per-lane write enable; lane i is di[i*MASK_W +: MASK_W].
- di  in  DW  write data.
- byp_sel  in  1  selects dbyp instead of array data into the output register.
- dbyp  in  DW  bypass data.
- err_clr  in  1  clears err_oob.
- err_oob  out  1  sticky out-of-range access flag.
- pwrbus_ram_pd  in  32  power bus; functionally ignored, kept for integration.

Behaviour:
- Reset (async, rst=1): ra_d=0, s1_vld=0, dout=0, dout_vld=0, err_oob=0. Array contents are untouched.
- rst deasserted mid-read: the pending read is discarded; dout_vld stays 0 until a new re→ore sequence.
- Write (edge): if we && wa<DEPTH, for each lane i with wmask[i]=1, M[wa] lane i <= di lane i. Other lanes hold.
  - we with wmask=0: no change.
  - we with wa≥DEPTH: no array write; err_oob <= 1.
- Read stage 1 (edge): if re, ra_d <= ra. s1_vld <= re every cycle. re with ra≥DEPTH: err_oob <= 1.
- Array output (combinational): dout_ram = (ra_d<DEPTH) ? M[ra_d] : 0.
- Read stage 2 (edge, when ore=1):
  - dout <= byp_sel ? dbyp : dout_ram.
  - dout_vld <= s1_vld | byp_sel.
  - ore=0: dout and dout_vld hold.
- Latency: re at edge N, ore at edge N+1 → data visible after edge N+1. This is 2-cycle re→dout.
- Collisions:
  - Write at edge N to an address read with re at edge N: the read returns new data, because the array is read after edge N.
  - Write to ra_d at the same edge as ore: the read returns old data.
  - Partial-mask write: only the masked lanes are new.
- byp_sel is sampled only when ore=1.
- err_oob:
  - Set has priority over err_clr in the same cycle.
  - err_clr alone → 0 next edge.
- Contention assertion (simulation only): flags we && re && wa==ra with any wmask bit set. It is suppressed during rst unless the parameter is 1.
- Uninitialised locations read as X in simulation. No reset of M.

Decomposition:
- A shared package sa_ram_pkg holds:
  - a clog2-safe AW function (minimum 1);
  - the lane-count function NM(DW, MASK_W);
  - the OOB/contention check macros reused by other RAM models.
- Natural sub-module: sa_ram_outreg. It is the output register with bypass mux and dout_vld, reset-capable, parametrised by DW. It is reused by single-port variants.
- The array plus write mask stays in the top module.

Test Plan (all at DW=4, DEPTH=20, MASK_W=1 unless noted):
- Reset: assert rst mid-read (re at N, rst at N+0.5) → dout=0, dout_vld=0, err_oob=0. After release, ore alone keeps dout_vld=0.
- Basic: write wa=7, di=4'hA, wmask=4'hF. Next cycle re, ra=7; following cycle ore → dout=4'hA, dout_vld=1, two cycles after re.
- Mask: M[3]=4'h0, then write di=4'hF, wmask=4'b0101 → read returns 4'h5. wmask=0 write leaves 4'h5.
- Collisions:
  - we wa=5 di=4'h6 at the same edge as re ra=5 → dout=4'h6.
  - With M[5]=4'h6, write di=4'h9 at the ore edge → dout=4'h6; the next read gives 4'h9.
- Bypass/hold: ore with byp_sel=1, dbyp=4'hC and no prior re → dout=4'hC, dout_vld=1. ore=0 for 3 cycles → dout holds 4'hC.
- OOB: we wa=20 → array unchanged, err_oob=1. re ra=25 then ore → dout=0. err_clr together with a new OOB → err_oob stays 1. err_clr alone → 0.
